// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: condition-code encodings and NZCV bit positions shared by alu, decoder and cond_unit
package cond_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_unit_cond_check.sv
// cond_check: combinational evaluation of a condition field against stored NZCV
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex,
  output logic       o_undef
);
  logic w_n, w_z, w_c, w_v;
  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];
  assign o_undef = (i_cond == COND_NV);
  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register plus condition-gated write enables for the decoder outputs
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       CondExR,
  output logic       Undef,
  output logic [3:0] Flags
);
  logic [3:0] r_flags;
  logic       r_cond_ex;
  logic       w_cond_ex, w_undef, w_go;
  cond_check u_check (
    .i_cond   (Cond),
    .i_flags  (r_flags),
    .o_cond_ex(w_cond_ex),
    .o_undef  (w_undef)
  );
  assign w_go     = w_cond_ex & ~Stall;
  assign PCSrc    = PCS & w_go;
  assign RegWrite = RegW & ~NoWrite & w_go;
  assign MemWrite = MemW & w_go;
  assign CondEx   = w_cond_ex;
  assign CondExR  = r_cond_ex;
  assign Undef    = w_undef;
  assign Flags    = r_flags;
  // N,Z and C,V halves are written independently so logical ops can keep C/V
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags   <= FLAG_RESET;
      r_cond_ex <= 1'b0;
    end else begin
      if (FlagW[1] & w_go) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0] & w_go) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      if (!Stall) r_cond_ex <= w_cond_ex;
    end
  end
endmodule
